// File: rtl/vertex_stream_loader_pkg.sv
// vertex_pkg: fixed-point vertex word type and loader FSM states
package vertex_pkg;
    localparam int M = 11;
    localparam int N = 7;
    localparam int W = M + N;
    typedef logic signed [W-1:0] vertex_word_t;
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, LAUNCH, WAIT_DONE, ERROR} loader_state_e;
endpackage

// File: rtl/vertex_stream_loader_if.sv
// vertex_stream_loader_if: valid/ready stream of signed vertex component words
interface vertex_stream_loader_if;
    import vertex_pkg::*;
    vertex_word_t data;
    logic valid;
    logic last;
    logic ready;
    modport master(output data, valid, last, input ready);
    modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/vertex_stream_loader_mem_writer.sv
// vertex_mem_writer: registered write stage turning accepted stream words into memory writes
module vertex_mem_writer
    import vertex_pkg::*;
#(
    parameter int DEPTH = 16384
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     hs,
    input  vertex_word_t             din,
    output logic [31:0]              wc,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output vertex_word_t             wr_data,
    output logic                     wr_en
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0] wc_q, wc_d;
    logic [AW-1:0] addr_q, addr_d;
    vertex_word_t data_q, data_d;
    logic en_q, en_d;
    always_comb begin
        wc_d = clear ? '0 : wc_q + 32'(hs);
        en_d = hs;
        addr_d = hs ? wc_q[AW-1:0] : addr_q;
        data_d = hs ? din : data_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wc_q <= '0;
            en_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wc_q <= wc_d;
            en_q <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end
    assign wc = wc_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign wr_en = en_q;
endmodule

// File: rtl/vertex_stream_loader.sv
// vertex_stream_loader: streams fixed-point vertex words into GPU vertex memory and launches GPU_top
module vertex_stream_loader
    import vertex_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int COMPONENTS = 3,
    parameter int AUTO_START = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_req,
    vertex_stream_loader_if.slave    s,
    output logic [$clog2(DEPTH)-1:0] mem_wr_addr,
    output vertex_word_t             mem_wr_data,
    output logic                     mem_wr_en,
    output logic [31:0]              vertex_count,
    output logic [31:0]              vert_total,
    output logic                     gpu_start,
    input  logic                     gpu_done,
    output logic                     busy,
    output logic                     load_ok,
    output logic                     err_overflow,
    output logic                     err_align
);
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || COMPONENTS < 1 || COMPONENTS > 4) begin : g_bad_params
        $error("vertex_stream_loader: DEPTH must be a power of two >= 4 and COMPONENTS 1..4");
    end
    loader_state_e state_q, state_d;
    logic [31:0] wc, cc_q, cc_d, vc_q, vc_d, vcount_q, vcount_d, vtotal_q, vtotal_d;
    logic err_ov_q, err_ov_d, err_al_q, err_al_d, load_ok_q, load_ok_d, gpu_start_q, gpu_start_d;
    logic ready, hs, clear, cc_wrap;
    assign ready = state_q == LOAD && wc < 32'(DEPTH);
    assign hs = s.valid && ready;
    assign cc_wrap = cc_q == 32'(COMPONENTS - 1);
    assign gpu_start_d = state_q == LAUNCH;
    vertex_mem_writer #(.DEPTH(DEPTH)) u_writer (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .hs(hs),
        .din(s.data),
        .wc(wc),
        .wr_addr(mem_wr_addr),
        .wr_data(mem_wr_data),
        .wr_en(mem_wr_en)
    );
    always_comb begin
        state_d = state_q;
        cc_d = cc_q;
        vc_d = vc_q;
        vcount_d = vcount_q;
        vtotal_d = vtotal_q;
        err_ov_d = err_ov_q;
        err_al_d = err_al_q;
        load_ok_d = 1'b0;
        clear = 1'b0;
        case (state_q)
            IDLE, ERROR: if (load_req) begin
                state_d = LOAD;
                cc_d = '0;
                vc_d = '0;
                err_ov_d = 1'b0;
                err_al_d = 1'b0;
                clear = 1'b1;
            end
            LOAD: if (hs) begin
                cc_d = cc_wrap ? '0 : cc_q + 32'd1;
                vc_d = vc_q + 32'(cc_wrap);
                state_d = s.last ? CHECK : LOAD;
            end else if (s.valid) begin
                // a valid word with ready low means the memory is already full
                state_d = ERROR;
                err_ov_d = 1'b1;
            end
            CHECK: if (cc_q != '0) begin
                state_d = ERROR;
                err_al_d = 1'b1;
            end else begin
                vcount_d = wc;
                vtotal_d = vc_q;
                state_d = AUTO_START != 0 ? LAUNCH : IDLE;
                load_ok_d = AUTO_START == 0;
            end
            LAUNCH: state_d = WAIT_DONE;
            WAIT_DONE: if (gpu_done) begin
                state_d = IDLE;
                load_ok_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cc_q <= '0;
            vc_q <= '0;
            vcount_q <= '0;
            vtotal_q <= '0;
            err_ov_q <= 1'b0;
            err_al_q <= 1'b0;
            load_ok_q <= 1'b0;
            gpu_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q <= cc_d;
            vc_q <= vc_d;
            vcount_q <= vcount_d;
            vtotal_q <= vtotal_d;
            err_ov_q <= err_ov_d;
            err_al_q <= err_al_d;
            load_ok_q <= load_ok_d;
            gpu_start_q <= gpu_start_d;
        end
    end
    assign s.ready = ready;
    assign busy = state_q != IDLE && state_q != ERROR;
    assign vertex_count = vcount_q;
    assign vert_total = vtotal_q;
    assign gpu_start = gpu_start_q;
    assign load_ok = load_ok_q;
    assign err_overflow = err_ov_q;
    assign err_align = err_al_q;
endmodule
